// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide sequencer: FSM encodings,
// divide step count, data/result widths and an operand magnitude helper.
package muldiv_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] FIX  = 2'd3;

   localparam int unsigned DIV_STEPS = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned RESULT_W  = 64;

   function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v, input logic sgn);
      return (sgn && v[DATA_W-1]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide unit signal bundle. master = EX pipeline,
// slave = muldiv_ctrl.
interface muldiv_ctrl_if;

   logic        mult_ex;
   logic        div_ex;
   logic        signed_ex;
   logic [31:0] sourceA_ex;
   logic [31:0] sourceB_ex;
   logic        mfhi_ex;
   logic        mflo_ex;
   logic        mthi_ex;
   logic        mtlo_ex;
   logic        ovf_check_ex;
   logic        flush;
   logic        busy;
   logic        stall_md;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_by_zero;
   logic        overflow_trap_md;

   modport master (
      output mult_ex, div_ex, signed_ex, sourceA_ex, sourceB_ex,
             mfhi_ex, mflo_ex, mthi_ex, mtlo_ex, ovf_check_ex, flush,
      input  busy, stall_md, hi_out, lo_out, div_by_zero, overflow_trap_md
   );

   modport slave (
      input  mult_ex, div_ex, signed_ex, sourceA_ex, sourceB_ex,
             mfhi_ex, mflo_ex, mthi_ex, mtlo_ex, ovf_check_ex, flush,
      output busy, stall_md, hi_out, lo_out, div_by_zero, overflow_trap_md
   );

endinterface

// File: rtl/muldiv_divider.sv
// Iterative restoring divide core: one quotient bit per step, operands are
// unsigned magnitudes; sign handling lives in muldiv_ctrl.
module muldiv_divider
   import muldiv_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o
);

   logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [DATA_W:0]   shifted;
   logic [DATA_W+1:0] trial;
   logic              unused_bits;

   // Shifted remainder can reach 33 bits; a failed trial implies it fits in 32.
   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      shifted = {rem_q, quo_q[DATA_W-1]};
      trial   = {1'b0, shifted} - {2'b00, dvs_q};
      if (load_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
      end else if (step_i) begin
         if (!trial[DATA_W+1]) begin
            rem_d = trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
         end else begin
            rem_d = shifted[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
      end
   end

   assign unused_bits = trial[DATA_W] ^ shifted[DATA_W];
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for EX. Optional signed multiply
// overflow trap enabled by defining MULDIV_OVF_TRAP_EN.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_ctrl_if.slave md
);

   logic [1:0]          state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic                sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d;
   logic                load, step, dbz, trap;
   logic [RESULT_W-1:0] ea, eb, prod;
   logic [DATA_W-1:0]   quo, rem, q_fix, r_fix;
`ifdef MULDIV_OVF_TRAP_EN
   logic                ovf_chk_q, ovf_chk_d;
`else
   logic                unused_ovf_check;
   assign unused_ovf_check = md.ovf_check_ex;
`endif

   muldiv_divider u_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load),
      .step_i      (step),
      .dividend_i  (abs32(md.sourceA_ex, md.signed_ex)),
      .divisor_i   (abs32(md.sourceB_ex, md.signed_ex)),
      .quotient_o  (quo),
      .remainder_o (rem)
   );

   assign ea    = sgn_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
   assign eb    = sgn_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
   assign prod  = ea * eb;
   assign q_fix = (sa_q ^ sb_q) ? (~quo + 32'd1) : quo;
   assign r_fix = sa_q ? (~rem + 32'd1) : rem;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      load    = 1'b0;
      step    = 1'b0;
      dbz     = 1'b0;
      trap    = 1'b0;
`ifdef MULDIV_OVF_TRAP_EN
      ovf_chk_d = ovf_chk_q;
`endif
      if (md.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (md.mult_ex || md.div_ex) begin
                  a_d   = md.sourceA_ex;
                  b_d   = md.sourceB_ex;
                  sgn_d = md.signed_ex;
                  sa_d  = md.signed_ex & md.sourceA_ex[DATA_W-1];
                  sb_d  = md.signed_ex & md.sourceB_ex[DATA_W-1];
`ifdef MULDIV_OVF_TRAP_EN
                  ovf_chk_d = md.ovf_check_ex;
`endif
               end
               if (md.mult_ex) begin
                  state_d = MUL;
                  cnt_d   = 5'(MUL_LAT - 1);
               end else if (md.div_ex) begin
                  state_d = DIV;
                  cnt_d   = 5'(DIV_STEPS - 1);
                  load    = 1'b1;
               end
               if (md.mthi_ex) hi_d = md.sourceA_ex;
               if (md.mtlo_ex) lo_d = md.sourceA_ex;
            end
            MUL: begin
               if (cnt_q == '0) begin
                  {hi_d, lo_d} = prod;
                  state_d      = IDLE;
`ifdef MULDIV_OVF_TRAP_EN
                  trap = sgn_q & ovf_chk_q & ~((&prod[63:31]) | ~(|prod[63:31]));
`endif
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            DIV: begin
               step = 1'b1;
               if (cnt_q == '0) state_d = FIX;
               else             cnt_d   = cnt_q - 5'd1;
            end
            FIX: begin
               if (b_q == '0) begin
                  hi_d = a_q;
                  lo_d = '1;
                  dbz  = 1'b1;
               end else begin
                  hi_d = r_fix;
                  lo_d = q_fix;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

`ifdef MULDIV_OVF_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_chk_q <= 1'b0;
      else        ovf_chk_q <= ovf_chk_d;
   end
`endif

   assign md.busy             = (state_q != IDLE);
   assign md.stall_md         = md.busy & (md.mult_ex | md.div_ex | md.mfhi_ex |
                                           md.mflo_ex | md.mthi_ex | md.mtlo_ex);
   assign md.hi_out           = hi_q;
   assign md.lo_out           = lo_q;
   assign md.div_by_zero      = dbz;
   assign md.overflow_trap_md = trap;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic
// reference model of HI/LO results, latency and pulse counts.
module tb_muldiv_ctrl;

   localparam int unsigned MUL_LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   always #5 clk = ~clk;

   muldiv_ctrl_if md();

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (md)
   );

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      md.mult_ex = 0; md.div_ex = 0; md.signed_ex = 0; md.ovf_check_ex = 0;
      md.sourceA_ex = '0; md.sourceB_ex = '0;
      md.mfhi_ex = 0; md.mflo_ex = 0; md.mthi_ex = 0; md.mtlo_ex = 0;
      md.flush = 0;
   endtask

   function automatic void model(input bit is_div, input bit sgn, input bit ovchk,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output int lat, output int dbz, output int ovf);
      int sa, sb;
      longint p, lim;
      longint unsigned pu;
      sa = a; sb = b; dbz = 0; ovf = 0;
      lim = 64'sh7FFF_FFFF;
      if (!is_div) begin
         lat = MUL_LAT;
         if (sgn) begin
            p = longint'(sa) * longint'(sb);
            {hi, lo} = p;
`ifdef MULDIV_OVF_TRAP_EN
            if (ovchk && (p > lim || p < -lim - 1)) ovf = 1;
`else
            if (ovchk && p > lim) ovf = 0;
`endif
         end else begin
            pu = {32'b0, a} * {32'b0, b};
            {hi, lo} = pu;
         end
      end else begin
         lat = 33;
         if (b == 0) begin
            hi = a; lo = 32'hFFFF_FFFF; dbz = 1;
         end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = 0;
            end else begin
               lo = sa / sb; hi = sa % sb;
            end
         end else begin
            lo = a / b; hi = a % b;
         end
      end
   endfunction

   task automatic run_op(input bit is_div, input bit sgn, input bit ovchk, input bit hold_mflo,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] ehi, elo;
      int elat, edbz, eovf;
      int n = 0, dbz = 0, ovf = 0, stall_bad = 0;
      model(is_div, sgn, ovchk, a, b, ehi, elo, elat, edbz, eovf);
      @(negedge clk);
      md.mult_ex = !is_div; md.div_ex = is_div; md.signed_ex = sgn;
      md.ovf_check_ex = ovchk; md.sourceA_ex = a; md.sourceB_ex = b;
      md.mflo_ex = hold_mflo;
      @(negedge clk);
      md.mult_ex = 0; md.div_ex = 0; md.ovf_check_ex = 0;
      md.signed_ex = 1'($urandom); md.sourceA_ex = $urandom; md.sourceB_ex = $urandom;
      while (md.busy && n < 100) begin
         if (md.div_by_zero) dbz++;
         if (md.overflow_trap_md) ovf++;
         if (hold_mflo && !md.stall_md) stall_bad++;
         n++;
         @(negedge clk);
      end
      chk_eq({tag, ".busy_cycles"}, n, elat);
      chk_eq({tag, ".hi"}, md.hi_out, ehi);
      chk_eq({tag, ".lo"}, md.lo_out, elo);
      chk_eq({tag, ".dbz_pulses"}, dbz, edbz);
      chk_eq({tag, ".ovf_pulses"}, ovf, eovf);
      if (hold_mflo) begin
         chk_eq({tag, ".stall_while_busy_misses"}, stall_bad, 0);
         chk_eq({tag, ".stall_after_busy"}, md.stall_md, 0);
      end
      md.mflo_ex = 0;
      hi_m = ehi; lo_m = elo;
   endtask

   task automatic move_to(input bit to_hi, input logic [31:0] v);
      @(negedge clk);
      md.mthi_ex = to_hi; md.mtlo_ex = !to_hi; md.sourceA_ex = v;
      @(negedge clk);
      md.mthi_ex = 0; md.mtlo_ex = 0;
      if (to_hi) hi_m = v; else lo_m = v;
      chk_eq("mt.hi", md.hi_out, hi_m);
      chk_eq("mt.lo", md.lo_out, lo_m);
      chk_eq("mt.busy", md.busy, 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'd1;
         3: return 32'($urandom_range(0, 200));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int dbz, ovf;
      logic [31:0] b;
      clear_inputs();
      repeat (3) @(negedge clk);
      md.mult_ex = 1; md.mflo_ex = 1;
      #1;
      chk_eq("rst.busy", md.busy, 0);
      chk_eq("rst.stall", md.stall_md, 0);
      chk_eq("rst.hi", md.hi_out, 0);
      chk_eq("rst.lo", md.lo_out, 0);
      chk_eq("rst.dbz", md.div_by_zero, 0);
      chk_eq("rst.ovf", md.overflow_trap_md, 0);
      clear_inputs();
      @(negedge clk);
      rst_n = 1;

      run_op(0, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, "umul_ffff_x2");
      run_op(1, 1, 0, 0, -32'sd7, 32'd2, "sdiv_m7_2");
      run_op(1, 1, 0, 0, 32'd100, 32'd0, "div_100_0");
      run_op(1, 1, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_min_m1");
      run_op(1, 0, 0, 1, 32'd1000, 32'd7, "udiv_mflo_stall");
      run_op(0, 1, 1, 0, 32'h4000_0000, 32'd4, "smul_ovf");
      run_op(0, 0, 1, 0, 32'h4000_0000, 32'd4, "umul_no_ovf");

      // Flush ten cycles into a divide must leave HI/LO untouched.
      move_to(1, 32'd5);
      move_to(0, 32'd6);
      @(negedge clk);
      md.div_ex = 1; md.sourceA_ex = 32'd1000; md.sourceB_ex = 32'd0;
      @(negedge clk);
      md.div_ex = 0;
      repeat (9) @(negedge clk);
      chk_eq("flush.busy_before", md.busy, 1);
      md.flush = 1;
      dbz = md.div_by_zero; ovf = md.overflow_trap_md;
      @(negedge clk);
      md.flush = 0;
      chk_eq("flush.busy_after", md.busy, 0);
      chk_eq("flush.hi", md.hi_out, 32'd5);
      chk_eq("flush.lo", md.lo_out, 32'd6);
      chk_eq("flush.pulses", dbz + ovf + md.div_by_zero, 0);

      // Request accompanied by flush in IDLE is dropped.
      @(negedge clk);
      md.mult_ex = 1; md.mthi_ex = 1; md.sourceA_ex = 32'd9; md.sourceB_ex = 32'd9; md.flush = 1;
      @(negedge clk);
      clear_inputs();
      chk_eq("idle_flush.busy", md.busy, 0);
      chk_eq("idle_flush.hi", md.hi_out, 32'd5);

      for (int i = 0; i < 30; i++) begin
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
         run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), pick(), b, "rand");
      end

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      md.div_ex = 1; md.sourceA_ex = 32'd77; md.sourceB_ex = 32'd3; md.mflo_ex = 1;
      @(negedge clk);
      md.div_ex = 0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      chk_eq("midrst.busy", md.busy, 0);
      chk_eq("midrst.stall", md.stall_md, 0);
      chk_eq("midrst.hi", md.hi_out, 0);
      chk_eq("midrst.lo", md.lo_out, 0);
      clear_inputs();
      @(negedge clk);
      rst_n = 1;
      hi_m = 0; lo_m = 0;
      run_op(0, 1, 0, 0, -32'sd3, 32'd5, "smul_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer and HI/LO owner for the execute-stage multiply/divide resource. Accepts one multiply or divide per request from the execute stage, runs a fixed-latency multiply or a 32-step iterative restoring divide, writes the 64-bit result into architectural HI/LO registers, and stalls the pipeline when a dependent HI/LO access or a new request arrives while an operation is in flight. Sits beside the ALU in EX; HI/LO read data feeds the EX result mux.

## Interface
- MUL_LAT, 2, multiply latency in cycles (1..4)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mult_ex  input  1  multiply request
- div_ex  input  1  divide request (mult_ex and div_ex never both high)
- signed_ex  input  1  1 = signed operands, 0 = unsigned
- sourceA_ex  input  32  operand A / dividend
- sourceB_ex  input  32  operand B / divisor
- mfhi_ex, mflo_ex  input  1 each  HI/LO read request
- mthi_ex, mtlo_ex  input  1 each  HI/LO write request, data on sourceA_ex
- ovf_check_ex  input  1  request signed multiply overflow check
- flush  input  1  abort in-flight operation
- busy  output  1  operation in flight
- stall_md  output  1  combinational pipeline stall
- hi_out, lo_out  output  32 each  current HI/LO
- div_by_zero  output  1  one-cycle pulse on completion of divide with B = 0
- overflow_trap_md  output  1  one-cycle pulse, see Configuration

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE: mult_ex -> latch operands, MUL, counter = MUL_LAT-1. div_ex -> latch |A|, |B| (or raw if unsigned), signs, DIV, counter = 31. mthi/mtlo write HI/LO directly.
- MUL: counter decrements; at counter 0 write {HI,LO} = product (signed or unsigned per latched signed_ex), -> IDLE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); at counter 0 -> FIX.
- FIX: quotient negated if signed and sign(A) != sign(B); remainder negated if signed and A negative; write HI = remainder, LO = quotient; -> IDLE.
- Divide by zero: HI = raw sourceA_ex, LO = 32'hFFFF_FFFF, no sign fix, div_by_zero pulses in FIX cycle.
- Signed -2^31 / -1: LO = 32'h8000_0000, HI = 0, no trap.
- stall_md = busy & (mult_ex | div_ex | mfhi_ex | mflo_ex | mthi_ex | mtlo_ex). Requests while busy are not accepted; they are re-presented by the held pipeline.
- flush: any state -> IDLE next edge, HI/LO unchanged, no pulses. flush in IDLE with a request: request dropped.
- Reset mid-operation: state IDLE, all outputs to reset values immediately.

## Timing
- Reset values: busy 0, stall_md 0, hi_out 0, lo_out 0, div_by_zero 0, overflow_trap_md 0, state IDLE.
- Request accepted on edge where state is IDLE; busy high from next cycle.
- Multiply: busy for MUL_LAT cycles; HI/LO valid the cycle after the last MUL cycle.
- Divide: busy for 33 cycles (32 DIV + 1 FIX); HI/LO valid on cycle 34 after acceptance.
- mthi/mtlo in IDLE: hi_out/lo_out update next cycle.
- Back-to-back: a new request can be accepted in the first cycle busy is low.
- busy is registered; stall_md is combinational from busy and requests.

## Configuration
- MULDIV_OVF_TRAP_EN defined: on multiply completion with latched signed_ex and ovf_check_ex, overflow_trap_md pulses one cycle if product[63:31] not all equal; HI/LO still written.
- Undefined: overflow_trap_md tied 0, ovf_check_ex ignored, no overflow logic synthesized.

## Structure
- muldiv_pkg: state enum (IDLE, MUL, DIV, FIX), DIV_STEPS = 32, result width constants.
- Sub-module muldiv_divider: iterative restoring core (remainder/quotient/divisor registers, step enable, load); muldiv_ctrl holds FSM, counters, sign handling, HI/LO.

## Test plan
- Unsigned mult 32'hFFFF_FFFF * 2, MUL_LAT=2 -> busy 2 cycles, HI=1, LO=32'hFFFF_FFFE.
- Signed div -7 / 2 -> busy 33 cycles, LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- Div 100 / 0 -> HI=100, LO=32'hFFFF_FFFF, div_by_zero one pulse in FIX cycle.
- mflo_ex during divide -> stall_md high every busy cycle, low when busy drops, LO then correct.
- flush at DIV cycle 10 after HI/LO = 5/6 -> IDLE next cycle, HI=5, LO=6, no pulses.
- With MULDIV_OVF_TRAP_EN, signed 32'h4000_0000 * 4, ovf_check_ex=1 -> overflow_trap_md pulse, HI=1, LO=0; without macro no pulse.
